// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for systolic_skew_feeder: FSM state encoding and default sizes.
// Optional row counter is enabled with the ROW_COUNT_EN macro.
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam int unsigned DEF_N  = 4;
    localparam int unsigned DEF_DW = 8;
    localparam int unsigned DEF_CW = 8;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One skew lane: a DEPTH-stage data+valid shift register that advances every cycle.
module skew_lane #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // NOTE: the whole delay line is reset, not just the valid tags, because
    // a_out must read zero after reset; this is small flop storage, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= in_data_i;
            valid_q[0] <= in_valid_i;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Captures row vectors on load and feeds them diagonally skewed into the array west edge.
// Define ROW_COUNT_EN to add the saturating per-frame row_count_o output.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned DW = DEF_DW
`ifdef ROW_COUNT_EN
    ,
    parameter int unsigned CW = DEF_CW
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            last_i,
    input  logic [N*DW-1:0] row_in_i,
    output logic            ready_o,
    output logic [N*DW-1:0] a_out_o,
    output logic [N-1:0]    a_valid_o,
    output logic            busy_o,
`ifdef ROW_COUNT_EN
    output logic [CW-1:0]   row_count_o,
`endif
    output logic            done_o
);

    localparam int unsigned DCW = cnt_width(N);

    state_e         state_q, state_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           accept;

    assign ready_o = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign accept  = load_i & ready_o;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept && last_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(N - 1);
                end else if (accept) begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

`ifdef ROW_COUNT_EN
    logic [CW-1:0] rc_q, rc_d;

    // Frame count survives DONE and clears on the way back to IDLE.
    always_comb begin
        rc_d = rc_q;
        if (state_q == ST_DONE)         rc_d = '0;
        else if (accept && rc_q != '1)  rc_d = rc_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rc_q <= '0;
        else     rc_q <= rc_d;
    end

    assign row_count_o = rc_q;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        skew_lane #(
            .DEPTH (gi + 1),
            .DW    (DW)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (accept),
            .in_data_i   (accept ? row_in_i[gi*DW +: DW] : '0),
            .out_valid_o (a_valid_o[gi]),
            .out_data_o  (a_out_o[gi*DW +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder (N=4, DW=8); honours ROW_COUNT_EN.
module tb_systolic_skew_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        last = 1'b0;
    logic [31:0] row_in = '0;
    logic        ready, busy, done;
    logic [31:0] a_out;
    logic [3:0]  a_valid;
`ifdef ROW_COUNT_EN
    logic [7:0]  row_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(4), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .last_i      (last),
        .row_in_i    (row_in),
        .ready_o     (ready),
        .a_out_o     (a_out),
        .a_valid_o   (a_valid),
        .busy_o      (busy),
`ifdef ROW_COUNT_EN
        .row_count_o (row_count),
`endif
        .done_o      (done)
    );

    typedef struct {
        logic        load;
        logic        last;
        logic [31:0] row;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic [7:0]  rc;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic ld, input logic ls, input logic [31:0] r,
                                input logic [3:0] v, input logic [31:0] d,
                                input logic rd, input logic bs, input logic dn,
                                input logic [7:0] rc);
        vec_t x;
        x.load = ld; x.last = ls; x.row = r; x.valid = v; x.data = d;
        x.rdy = rd; x.bsy = bs; x.dn = dn; x.rc = rc;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a_valid"}, 32'(a_valid), 32'h0);
        check({tag, " a_out"},   a_out,        32'h0);
        check({tag, " ready"},   32'(ready),   32'h1);
        check({tag, " busy"},    32'(busy),    32'h0);
        check({tag, " done"},    32'(done),    32'h0);
    endtask

    initial begin
        // Single-row frame, loads during DRAIN/DONE, back-to-back frame, stray last.
        tbl[0]  = mk(1, 1, 32'h44332211, 4'b0001, 32'h00000011, 0, 1, 0, 1);
        tbl[1]  = mk(0, 0, 32'h00000000, 4'b0010, 32'h00002200, 0, 1, 0, 1);
        tbl[2]  = mk(1, 0, 32'hFFFFFFFF, 4'b0100, 32'h00330000, 0, 1, 0, 1);
        tbl[3]  = mk(0, 0, 32'h00000000, 4'b1000, 32'h44000000, 0, 1, 0, 1);
        tbl[4]  = mk(0, 1, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 1, 1);
        tbl[5]  = mk(1, 1, 32'hFFFFFFFF, 4'b0000, 32'h00000000, 1, 0, 0, 0);
        tbl[6]  = mk(1, 1, 32'hA4A3A2A1, 4'b0001, 32'h000000A1, 0, 1, 0, 1);
        tbl[7]  = mk(0, 0, 32'h00000000, 4'b0010, 32'h0000A200, 0, 1, 0, 1);
        tbl[8]  = mk(0, 0, 32'h00000000, 4'b0100, 32'h00A30000, 0, 1, 0, 1);
        tbl[9]  = mk(0, 0, 32'h00000000, 4'b1000, 32'hA4000000, 0, 1, 0, 1);
        tbl[10] = mk(0, 0, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 1, 1);
        tbl[11] = mk(0, 1, 32'h00000000, 4'b0000, 32'h00000000, 1, 0, 0, 0);
        tbl[12] = mk(0, 1, 32'h00000000, 4'b0000, 32'h00000000, 1, 0, 0, 0);
        // Three-row frame, loads every other cycle, last on the third.
        tbl[13] = mk(1, 0, 32'h13121110, 4'b0001, 32'h00000010, 1, 1, 0, 1);
        tbl[14] = mk(0, 0, 32'h00000000, 4'b0010, 32'h00001100, 1, 1, 0, 1);
        tbl[15] = mk(1, 0, 32'h23222120, 4'b0101, 32'h00120020, 1, 1, 0, 2);
        tbl[16] = mk(0, 1, 32'h00000000, 4'b1010, 32'h13002100, 1, 1, 0, 2);
        tbl[17] = mk(1, 1, 32'h33323130, 4'b0101, 32'h00220030, 0, 1, 0, 3);
        tbl[18] = mk(0, 0, 32'h00000000, 4'b1010, 32'h23003100, 0, 1, 0, 3);
        tbl[19] = mk(0, 0, 32'h00000000, 4'b0100, 32'h00320000, 0, 1, 0, 3);
        tbl[20] = mk(0, 0, 32'h00000000, 4'b1000, 32'h33000000, 0, 1, 0, 3);
        tbl[21] = mk(0, 0, 32'h00000000, 4'b0000, 32'h00000000, 0, 1, 1, 3);
        tbl[22] = mk(0, 0, 32'h00000000, 4'b0000, 32'h00000000, 1, 0, 0, 0);

        // Reset asserted from time 0 and released mid-cycle; outputs idle throughout.
        #3;
        check_idle("rst_held");
        #5 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle($sformatf("idle%0d", c));
        end

        for (int k = 0; k < NV; k++) begin
            load   = tbl[k].load;
            last   = tbl[k].last;
            row_in = tbl[k].row;
            step();
            check($sformatf("v%0d a_valid", k), 32'(a_valid), 32'(tbl[k].valid));
            check($sformatf("v%0d a_out", k),   a_out,        tbl[k].data);
            check($sformatf("v%0d ready", k),   32'(ready),   32'(tbl[k].rdy));
            check($sformatf("v%0d busy", k),    32'(busy),    32'(tbl[k].bsy));
            check($sformatf("v%0d done", k),    32'(done),    32'(tbl[k].dn));
`ifdef ROW_COUNT_EN
            check($sformatf("v%0d row_count", k), 32'(row_count), 32'(tbl[k].rc));
`endif
        end
        load = 1'b0; last = 1'b0; row_in = '0;

        // Abort in STREAM while lane 3 holds a valid row.
        load = 1'b1; row_in = 32'h54535251;
        step();
        load = 1'b0; row_in = '0;
        step(); step(); step();
        check("abort pre a_valid", 32'(a_valid), 32'h8);
        check("abort pre a_out",   a_out,        32'h54000000);
        check("abort pre busy",    32'(busy),    32'h1);
        #2 rst = 1'b1;
        #1;
        check_idle("abort async");
        #2 rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            check_idle($sformatf("post_abort%0d", c));
        end
`ifdef ROW_COUNT_EN
        check("post_abort row_count", 32'(row_count), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Downstream consumer of the test-control load strobe. On each `load` pulse it captures one row vector (N elements) and injects it into the systolic array's west edge with diagonal skew: lane i is delayed i cycles relative to lane 0. It tracks frame boundaries and signals `done` once the last row has fully drained from every lane.

Parameters:
N, 4, number of lanes (array rows); N >= 1
DW, 8, element width in bits
CW, 8, row-counter width (ROW_COUNT_EN only)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
load  input  1  one-cycle strobe: capture row_in this cycle
last  input  1  qualifies load: this row ends the frame
row_in  input  N*DW  row vector; lane i = row_in[i*DW +: DW]
ready  output  1  1 when a load will be accepted (state IDLE or STREAM)
a_out  output  N*DW  skewed lane data to the array
a_valid  output  N  per-lane valid tag
busy  output  1  1 in STREAM, DRAIN or DONE
done  output  1  one-cycle pulse after the frame has fully drained
row_count  output  CW  rows accepted in the current frame (ROW_COUNT_EN only)

Behaviour:
- Reset: clk/rst; rst is asynchronous and active-high. It clears all delay registers, a_out=0, a_valid=0, state=IDLE, done=0, busy=0, ready=1, and drain counter=0.
- Lane i is a chain of i+1 registers (data + valid tag) that advances every cycle, with no stall.
  - Accepted load at edge t: stage 0 of lane i gets row_in lane i and valid=1.
  - No accepted load: stage 0 gets data 0 and valid 0.
- Latency: lane i data appears on a_out/a_valid in the cycle after edge t+i.
- Accepted load = load & ready. A load while not ready is dropped: no lane change, no counter change.
- FSM:
  - IDLE: busy=0. Accepted load with last=0 goes to STREAM. Accepted load with last=1 goes to DRAIN.
  - STREAM: busy=1, ready=1. Accepted load with last=1 goes to DRAIN. Otherwise stay.
  - DRAIN: ready=0. Entry loads drain_cnt=N-1. At each edge, drain_cnt==0 goes to DONE, otherwise drain_cnt decrements.
  - DONE: done=1 and ready=0 for exactly one cycle, then IDLE.
- Timing: done is asserted the cycle after lane N-1 presents the final row.
  - N=1: the DRAIN stay is one cycle.
- `last` without `load` is ignored.
- Reset mid-frame aborts immediately: all lanes are invalidated and no done is issued.

Optional Feature:
- Macro ROW_COUNT_EN.
- Defined:
  - row_count port exists and resets to 0.
  - Increments on each accepted load and saturates at 2^CW-1.
  - Cleared on the IDLE entry following DONE.
  - Holds its final value during DONE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, STREAM=2'b01, DRAIN=2'b10, DONE=2'b11.
  - Default lane/width constants (N, DW).
- Natural sub-module: skew_lane, parameterised by DEPTH and DW. It is a DEPTH-stage data+valid shift register with async reset, instantiated N times with DEPTH=i+1 via generate.

Test Plan:
All scenarios use N=4, DW=8.
1. Reset then idle: rst pulse mid-cycle, no loads -> a_valid=4'b0000, a_out=0, ready=1, busy=0, done=0 throughout.
2. Single-row frame: load=1, last=1, row_in={8'h44,8'h33,8'h22,8'h11} at edge t.
   -> lane0=8'h11 valid after t; lane1=8'h22 after t+1; lane2=8'h33 after t+2; lane3=8'h44 after t+3.
   -> done=1 in the cycle after t+4, then IDLE.
3. Three-row frame with loads every other cycle (rows 01..,02..,03.., last on third):
   -> each lane shows valid rows separated by one invalid bubble.
   -> done fires exactly once, 4 cycles after the third load.
   -> with ROW_COUNT_EN, row_count=3 during DONE.
4. Load during DRAIN/DONE -> ready=0, row dropped, a_valid unaffected, done timing unchanged.
5. rst asserted in STREAM with lane3 still holding a valid row -> a_valid=0 asynchronously, state=IDLE, no done pulse afterwards.
6. Back-to-back frames: last-load, then a new load the cycle after DONE -> accepted, busy=1, second done after its own drain.
